// File: rtl/shift_reg_ctrl_pkg.sv
// shift_reg_ctrl_pkg: shared FSM state type and SRAM timing constant for the shift register sequencer.
package shift_reg_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;
    localparam int SRAM_LAT = 1;
endpackage

// File: rtl/shift_reg_ctrl_if.sv
// shift_reg_ctrl_if: job, SRAM, register-file and bit-serial handshake signals of the sequencer.
// stall_cnt exists only when SHIFT_REG_CTRL_PERF_CNT_EN is defined.
interface shift_reg_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 8
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_vec;
    logic              abort;
    logic              busy;
    logic              done;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_addr;
    logic              rf_w_en;
    logic              rf_r_en;
    logic              bit_valid;
    logic              bit_ready;
    logic [IDX_W-1:0]  bit_idx;
    logic              last_bit;
    logic              last_vec;
`ifdef SHIFT_REG_CTRL_PERF_CNT_EN
    logic [31:0]       stall_cnt;
`endif
    modport master (
`ifdef SHIFT_REG_CTRL_PERF_CNT_EN
        input  stall_cnt,
`endif
        output start, base_addr, num_vec, abort, bit_ready,
        input  busy, done, sram_ren, sram_addr, rf_w_en, rf_r_en,
               bit_valid, bit_idx, last_bit, last_vec
    );
    modport slave (
`ifdef SHIFT_REG_CTRL_PERF_CNT_EN
        output stall_cnt,
`endif
        input  start, base_addr, num_vec, abort, bit_ready,
        output busy, done, sram_ren, sram_addr, rf_w_en, rf_r_en,
               bit_valid, bit_idx, last_bit, last_vec
    );
endinterface

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: fetches job vectors from SRAM into the shift register file and walks them MSB-first to the PE array.
// Define SHIFT_REG_CTRL_PERF_CNT_EN to add the saturating stall_cnt output.
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 8
) (
    input logic            clk,
    input logic            reset,
    shift_reg_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  vec_cnt;
    logic [IDX_W-1:0]  bit_cnt;
    logic              in_shift;
    logic              last_vec;

    assign in_shift = state == SHIFT;
    assign last_vec = vec_cnt == CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            vec_cnt <= '0;
            bit_cnt <= '0;
        end else if (bus.abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    addr    <= bus.base_addr;
                    vec_cnt <= bus.num_vec;
                    state   <= bus.num_vec == '0 ? DONE : FETCH;
                end
                FETCH: state <= LOAD;
                // SRAM data lands on the file input during LOAD (SRAM_LAT cycles after FETCH)
                LOAD: begin
                    bit_cnt <= IDX_W'(DATA_WIDTH - 1);
                    state   <= SHIFT;
                end
                SHIFT: if (bus.bit_ready) begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        vec_cnt <= vec_cnt - 1'b1;
                        addr    <= addr + 1'b1;
                        state   <= last_vec ? DONE : FETCH;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.sram_ren  = state == FETCH;
    assign bus.sram_addr = addr;
    assign bus.rf_w_en   = state == LOAD;
    assign bus.bit_valid = in_shift;
    assign bus.bit_idx   = in_shift ? bit_cnt : '0;
    assign bus.last_bit  = in_shift && bit_cnt == '0;
    assign bus.last_vec  = last_vec;
    // abort wins over the handshake, so the file never shifts in the abort cycle
    assign bus.rf_r_en   = in_shift & bus.bit_ready & ~bus.abort;

`ifdef SHIFT_REG_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (state == IDLE && bus.start && !bus.abort)
            stall_cnt <= '0;
        else if (in_shift && !bus.bit_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
    assign bus.stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: directed checks of the shift register sequencer against hand-derived cycle timelines.
module tb_shift_reg_ctrl;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_reg_ctrl_if #(.DATA_WIDTH(8), .ADDR_W(10), .CNT_W(8)) bus ();

    shift_reg_ctrl #(.DATA_WIDTH(8), .ADDR_W(10), .CNT_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {bus.busy, bus.done, bus.sram_ren, bus.rf_w_en, bus.rf_r_en,
                bus.bit_valid, bus.last_bit, bus.last_vec, bus.bit_idx};
    endfunction

    function automatic logic [10:0] pk(input logic bsy, dn, ren, wen, rd, vld, lb, lv,
                                       input logic [2:0] idx);
        return {bsy, dn, ren, wen, rd, vld, lb, lv, idx};
    endfunction

    // Called at posedge+1; each vector is FETCH, LOAD, then 8 shift slots, done after the last one
    task automatic run_job(input logic [9:0] base, input int n);
        logic [10:0] e;
        int k, p;
        bus.start = 1; bus.base_addr = base; bus.num_vec = 8'(n); bus.bit_ready = 1;
        @(posedge clk); #1 bus.start = 0;
        for (int c = 1; c <= 10 * n + 2; c++) begin
            @(negedge clk);
            e = '0; k = (c - 1) / 10; p = (c - 1) % 10;
            if (c <= 10 * n) begin
                if (p == 0)      e = pk(1, 0, 1, 0, 0, 0, 0, k == n - 1, 0);
                else if (p == 1) e = pk(1, 0, 0, 1, 0, 0, 0, k == n - 1, 0);
                else             e = pk(1, 0, 0, 0, 1, 1, p == 9, k == n - 1, 3'(9 - p));
                if (p == 0) check($sformatf("addr b%0h c%0d", base, c), 32'(bus.sram_addr), 32'((base + 10'(k)) & 10'h3ff));
            end else if (c == 10 * n + 1) begin
                e = pk(1, 1, 0, 0, 0, 0, 0, 0, 0);
            end
            check($sformatf("outs b%0h n%0d c%0d", base, n, c), 32'(outs()), 32'(e));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int eff;
        logic [5:0] e6;
        reset = 1; bus.start = 0; bus.base_addr = '0; bus.num_vec = '0; bus.abort = 0; bus.bit_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outs", 32'(outs()), 0);
        check("reset addr", 32'(bus.sram_addr), 0);
        reset = 0;
        @(posedge clk); #1;

        run_job(10'h010, 3);
        run_job(10'h123, 0);
        run_job(10'h3ff, 2);

        // stall: bit_ready low for cycles 5..8, which is while slice 5 is presented
        bus.start = 1; bus.base_addr = 10'h020; bus.num_vec = 8'd1; bus.bit_ready = 1;
        @(posedge clk); #1 bus.start = 0;
        for (int c = 1; c <= 16; c++) begin
            bus.bit_ready = !(c >= 5 && c <= 8);
            @(negedge clk);
            eff = c <= 4 ? c : (c <= 8 ? 5 : c - 4);
            if (c >= 3 && c <= 14) e6 = {1'b0, 1'b1, !(c >= 5 && c <= 8), 3'(10 - eff)};
            else if (c == 15)      e6 = 6'b100000;
            else                   e6 = '0;
            check($sformatf("stall c%0d", c), 32'({bus.done, bus.bit_valid, bus.rf_r_en, bus.bit_idx}), 32'(e6));
            @(posedge clk); #1;
        end
`ifdef SHIFT_REG_CTRL_PERF_CNT_EN
        check("stall_cnt", bus.stall_cnt, 4);
`endif

        // abort during slice 3 of the second of four vectors
        bus.start = 1; bus.base_addr = 10'h040; bus.num_vec = 8'd4; bus.bit_ready = 1;
        @(posedge clk); #1 bus.start = 0;
        repeat (16) @(posedge clk);
        #1 bus.abort = 1;
        @(negedge clk);
        check("abort idx", 32'(bus.bit_idx), 3);
        check("abort r_en", 32'(bus.rf_r_en), 0);
        @(posedge clk); #1 bus.abort = 0;
        @(negedge clk);
        check("abort busy", 32'({bus.busy, bus.done}), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort quiet", 32'({bus.busy, bus.done, bus.sram_ren}), 0);
        @(posedge clk); #1;
        run_job(10'h080, 1);

        // abort beats start in the same IDLE cycle
        bus.start = 1; bus.abort = 1; bus.num_vec = 8'd2;
        @(posedge clk); #1 bus.start = 0; bus.abort = 0;
        @(negedge clk);
        check("abort vs start", 32'(bus.busy), 0);
        @(posedge clk); #1;

        // asynchronous reset while in LOAD
        bus.start = 1; bus.base_addr = 10'h055; bus.num_vec = 8'd2;
        @(posedge clk); #1 bus.start = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-reset load", 32'(bus.rf_w_en), 1);
        #1 reset = 1;
        #1;
        check("async reset outs", 32'(outs()), 0);
        check("async reset addr", 32'(bus.sram_addr), 0);
        @(negedge clk) reset = 0;
        @(posedge clk); #1;
        run_job(10'h100, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
